piso_serializer: RTL

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer.sv | 94 +++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with optional trailing even-parity bit.
// Frames stream back-to-back when a new word arrives in the final frame cycle.
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1,
  parameter int unsigned PARITY_EN = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] pi,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             so,
  output logic             so_valid,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StPar} state_e;

  state_e          state_q;
  logic [WIDTH-1:0] sr_q;
  logic [CntW-1:0]  cnt_q;
  logic             par_q;

  logic             accept;
  logic [WIDTH-1:0] sr_adv;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  // done is registered and marks the final frame cycle, so it doubles as the reload window.
  assign load_ready = clr & ((state_q == StIdle) | done);
  assign accept     = load_valid & load_ready;
  assign sr_adv     = (MSB_FIRST != 0) ? (sr_q << 1) : (sr_q >> 1);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= StIdle;
      sr_q     <= '0;
      cnt_q    <= '0;
      par_q    <= 1'b0;
      so       <= 1'b0;
      so_valid <= 1'b0;
      done     <= 1'b0;
    end else if (accept) begin
      state_q  <= StShift;
      sr_q     <= pi;
      cnt_q    <= '0;
      par_q    <= ^pi;
      so       <= head_bit(pi);
      so_valid <= 1'b1;
      done     <= 1'b0;
    end else begin
      unique case (state_q)
        StShift: begin
          if (cnt_q == LastIdx) begin
            if (PARITY_EN != 0) begin
              state_q <= StPar;
              so      <= par_q;
              done    <= 1'b1;
            end else begin
              state_q  <= StIdle;
              so       <= 1'b0;
              so_valid <= 1'b0;
              done     <= 1'b0;
            end
          end else begin
            sr_q  <= sr_adv;
            cnt_q <= cnt_q + CntW'(1);
            so    <= head_bit(sr_adv);
            done  <= (cnt_q + CntW'(1) == LastIdx) && (PARITY_EN == 0);
          end
        end
        StPar: begin
          state_q  <= StIdle;
          so       <= 1'b0;
          so_valid <= 1'b0;
          done     <= 1'b0;
        end
        default: begin
          state_q  <= StIdle;
          so       <= 1'b0;
          so_valid <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule
